// File: rtl/program_load_ctrl.sv
// rtl/program_load_ctrl.sv - UART program loader and run/step/halt controller for the MIPS core
// Ports:
//   CLK, RESET                  system clock, asynchronous active-low reset
//   I_RX_EMPTY, I_RX_DATA       RX FIFO status and head byte (first-word-fall-through)
//   O_RD_UART                   RX FIFO pop strobe
//   O_PM_WE, O_PM_ADDR, O_PM_DATA  program memory write port
//   O_CPU_CLR                   holds the CPU pipeline in reset while loading
//   O_CPU_EN                    CPU clock enable
//   I_CPU_FINISHED              CPU reached its halt instruction
//   O_DUMP_START, I_DUMP_DONE   debug-unit dump handshake
//   O_CYCLES                    saturating count of enabled CPU cycles
//   O_ERR                       one-cycle protocol error pulse
//   O_STATE                     current state encoding
module program_load_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_RX_EMPTY,
  input  logic [7:0]        I_RX_DATA,
  output logic              O_RD_UART,
  output logic              O_PM_WE,
  output logic [ADDR_W-1:0] O_PM_ADDR,
  output logic [DATA_W-1:0] O_PM_DATA,
  output logic              O_CPU_CLR,
  output logic              O_CPU_EN,
  input  logic              I_CPU_FINISHED,
  output logic              O_DUMP_START,
  input  logic              I_DUMP_DONE,
  output logic [CNT_W-1:0]  O_CYCLES,
  output logic              O_ERR,
  output logic [2:0]        O_STATE
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BYTES = DATA_W / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] IDX_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [BW-1:0]   BYTE_ONE  = BW'(1);
  localparam logic [BW-1:0]   BYTE_LAST = BW'(BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    FILL     = 3'd2,
    WAIT_CMD = 3'd3,
    RUN      = 3'd4,
    STEP     = 3'd5,
    DUMP     = 3'd6
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   idx;
  logic [BW-1:0]     byte_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] word_next;
  logic [31:0]       rx_n;
  logic [CNT_W-1:0]  cycles;
  logic              pm_we, cpu_clr, dump_start, err;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_data;
  logic              rd_req, cpu_en, halt_req;

  assign rx_n      = {24'd0, I_RX_DATA};
  assign word_next = (shreg << 8) | DATA_W'(I_RX_DATA);
  assign halt_req  = !I_RX_EMPTY && (I_RX_DATA == 8'h04);

  // Pop and enable are combinational so a halt byte or the finished flag
  // stops the CPU in the very cycle it is seen.
  always_comb begin
    rd_req = 1'b0;
    cpu_en = 1'b0;
    case (state)
      IDLE, LOAD, WAIT_CMD: rd_req = !I_RX_EMPTY;
      RUN: begin
        rd_req = halt_req;
        cpu_en = !I_CPU_FINISHED && !halt_req;
      end
      STEP:    cpu_en = !I_CPU_FINISHED;
      default: ;
    endcase
  end

  // Gated with RESET so both read as 0 while reset is held.
  assign O_RD_UART = rd_req && RESET;
  assign O_CPU_EN  = cpu_en && RESET;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      n_words    <= '0;
      idx        <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      cycles     <= '0;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_data    <= '0;
      cpu_clr    <= 1'b0;
      dump_start <= 1'b0;
      err        <= 1'b0;
    end else begin
      pm_we      <= 1'b0;
      cpu_clr    <= 1'b0;
      dump_start <= 1'b0;
      err        <= 1'b0;

      if (cpu_en && cycles != '1)
        cycles <= cycles + CNT_ONE;

      case (state)
        IDLE: begin
          if (rd_req && rx_n != 32'd0) begin
            if (rx_n > DEPTH) begin
              err <= 1'b1;
            end else begin
              n_words  <= rx_n[ADDR_W:0];
              idx      <= '0;
              byte_cnt <= '0;
              cycles   <= '0;
              cpu_clr  <= 1'b1;
              state    <= LOAD;
            end
          end
        end

        LOAD: begin
          // CLR is registered here and in FILL so it also covers the
          // final memory write issued on the way out.
          cpu_clr <= 1'b1;
          if (rd_req) begin
            shreg <= word_next;
            if (byte_cnt == BYTE_LAST) begin
              byte_cnt <= '0;
              pm_we    <= 1'b1;
              pm_addr  <= idx[ADDR_W-1:0];
              pm_data  <= word_next;
              idx      <= idx + IDX_ONE;
              if (idx + IDX_ONE == n_words)
                state <= (n_words == IDX_DEPTH) ? WAIT_CMD : FILL;
            end else begin
              byte_cnt <= byte_cnt + BYTE_ONE;
            end
          end
        end

        FILL: begin
          cpu_clr <= 1'b1;
          pm_we   <= 1'b1;
          pm_addr <= idx[ADDR_W-1:0];
          pm_data <= '0;
          idx     <= idx + IDX_ONE;
          if (idx == IDX_LAST)
            state <= WAIT_CMD;
        end

        WAIT_CMD: begin
          if (rd_req) begin
            case (I_RX_DATA)
              8'h01:   state <= RUN;
              8'h02:   state <= STEP;
              8'h03:   state <= IDLE;
              8'h05: begin
                state      <= DUMP;
                dump_start <= 1'b1;
              end
              default: err <= 1'b1;
            endcase
          end
        end

        RUN: begin
          // A halt byte arriving with finished still yields a single dump.
          if (halt_req || I_CPU_FINISHED) begin
            state      <= DUMP;
            dump_start <= 1'b1;
          end
        end

        STEP: begin
          state      <= DUMP;
          dump_start <= 1'b1;
        end

        DUMP: begin
          if (I_DUMP_DONE)
            state <= WAIT_CMD;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign O_PM_WE      = pm_we;
  assign O_PM_ADDR    = pm_addr;
  assign O_PM_DATA    = pm_data;
  assign O_CPU_CLR    = cpu_clr;
  assign O_DUMP_START = dump_start;
  assign O_ERR        = err;
  assign O_CYCLES     = cycles;
  assign O_STATE      = state;

endmodule

// File: tb/tb_program_load_ctrl.sv
// tb/tb_program_load_ctrl.sv - self-checking bench for program_load_ctrl
module tb_program_load_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 32;
  localparam int DEPTH  = 32;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              I_RX_EMPTY;
  logic [7:0]        I_RX_DATA;
  logic              O_RD_UART;
  logic              O_PM_WE;
  logic [ADDR_W-1:0] O_PM_ADDR;
  logic [DATA_W-1:0] O_PM_DATA;
  logic              O_CPU_CLR;
  logic              O_CPU_EN;
  logic              I_CPU_FINISHED = 1'b0;
  logic              O_DUMP_START;
  logic              I_DUMP_DONE = 1'b0;
  logic [CNT_W-1:0]  O_CYCLES;
  logic              O_ERR;
  logic [2:0]        O_STATE;

  program_load_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_RX_EMPTY(I_RX_EMPTY), .I_RX_DATA(I_RX_DATA), .O_RD_UART(O_RD_UART),
    .O_PM_WE(O_PM_WE), .O_PM_ADDR(O_PM_ADDR), .O_PM_DATA(O_PM_DATA),
    .O_CPU_CLR(O_CPU_CLR), .O_CPU_EN(O_CPU_EN), .I_CPU_FINISHED(I_CPU_FINISHED),
    .O_DUMP_START(O_DUMP_START), .I_DUMP_DONE(I_DUMP_DONE),
    .O_CYCLES(O_CYCLES), .O_ERR(O_ERR), .O_STATE(O_STATE)
  );

  always #5 CLK = ~CLK;

  // RX FIFO model (first-word-fall-through)
  logic [7:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign I_RX_EMPTY = (rd_ptr == wr_ptr);
  assign I_RX_DATA  = fifo_mem[rd_ptr[9:0]];

  int bad_pop = 0;
  always @(posedge CLK) begin
    if (O_RD_UART && !I_RX_EMPTY) rd_ptr <= rd_ptr + 1;
    if (O_RD_UART && I_RX_EMPTY) bad_pop <= bad_pop + 1;
  end

  // Output monitor
  logic [ADDR_W+DATA_W-1:0] got_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int clr_bad = 0, err_we_bad = 0, err_cnt = 0, dump_cnt = 0, fill_seen = 0;
  always @(negedge CLK) begin
    if (O_PM_WE) begin
      got_q.push_back({O_PM_ADDR, O_PM_DATA});
      if (!O_CPU_CLR) clr_bad++;
      if (O_ERR) err_we_bad++;
    end
    if (O_ERR) err_cnt++;
    if (O_DUMP_START) dump_cnt++;
    if (O_STATE == 3'd2) fill_seen++;
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] exp_cycles = '0;

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[9:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge CLK);
      if (O_STATE == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic dump_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (O_DUMP_START) begin
        ok = 1'b1;
        break;
      end
    end
    I_DUMP_DONE = 1'b1;
    @(negedge CLK);
    I_DUMP_DONE = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int i);
    if (i == 0) return 32'h11223344;
    if (i == 1) return 32'hAABBCCDD;
    return {8'(i), 8'(i + 64), 8'(i + 128), 8'(i + 192)};
  endfunction

  task automatic load_and_check(input int n, input string name);
    int base, clr0, fill0, j;
    bit ok;
    logic [31:0] w;
    logic [ADDR_W+DATA_W-1:0] e, g;
    base = got_q.size();
    clr0 = clr_bad;
    fill0 = fill_seen;
    exp_q.delete();
    @(negedge CLK);
    push(8'(n));
    for (int i = 0; i < n; i++) begin
      w = word_of(i);
      push(w[31:24]); push(w[23:16]); push(w[15:8]); push(w[7:0]);
      exp_q.push_back({ADDR_W'(i), w});
    end
    for (int i = n; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), 32'h0});
    exp_cycles = '0;
    wait_state(3'd3, 1000, ok);
    repeat (3) @(negedge CLK);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s reach_wait_cmd: state %0d required 3", name, O_STATE); end
    n_checks++;
    if (got_q.size() - base != DEPTH) begin
      n_fail++; $display("FAIL %s write_count: got %0d required %0d", name, got_q.size() - base, DEPTH);
    end
    j = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (base + j >= got_q.size()) begin
        n_fail++; $display("FAIL %s pm_write_%0d: missing, required %h", name, j, e);
      end else begin
        g = got_q[base + j];
        if (g !== e) begin n_fail++; $display("FAIL %s pm_write_%0d: got %h required %h", name, j, g, e); end
      end
      j++;
    end
    n_checks++;
    if (clr_bad != clr0) begin n_fail++; $display("FAIL %s clr_during_write: %0d writes with CLR low, required 0", name, clr_bad - clr0); end
    if (n == DEPTH) begin
      n_checks++;
      if (fill_seen != fill0) begin n_fail++; $display("FAIL %s no_fill: %0d FILL cycles, required 0", name, fill_seen - fill0); end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_checks++;
    if (O_STATE !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", O_STATE); end
    n_checks++;
    if ({O_RD_UART, O_PM_WE, O_CPU_CLR, O_CPU_EN, O_DUMP_START, O_ERR} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 000000", {O_RD_UART, O_PM_WE, O_CPU_CLR, O_CPU_EN, O_DUMP_START, O_ERR});
    end
    n_checks++;
    if (O_PM_ADDR !== '0 || O_PM_DATA !== '0 || O_CYCLES !== '0) begin
      n_fail++; $display("FAIL reset_values: addr %h data %h cycles %0d required 0", O_PM_ADDR, O_PM_DATA, O_CYCLES);
    end
    RESET = 1'b1;
  endtask

  task automatic test_load2();
    load_and_check(2, "load2");
    n_checks++;
    if (O_CPU_CLR !== 1'b0) begin n_fail++; $display("FAIL load2_clr_released: got %b required 0", O_CPU_CLR); end
    n_checks++;
    if (O_CYCLES !== exp_cycles) begin n_fail++; $display("FAIL load2_cycles_cleared: got %0d required %0d", O_CYCLES, exp_cycles); end
  endtask

  task automatic test_boundary();
    bit ok;
    int err0;
    @(negedge CLK); push(8'h03);
    wait_state(3'd0, 20, ok);
    load_and_check(32, "load32");
    @(negedge CLK); push(8'h03);
    wait_state(3'd0, 20, ok);
    err0 = err_cnt;
    @(negedge CLK); push(8'd33);
    repeat (4) @(negedge CLK);
    n_checks++;
    if (err_cnt != err0 + 1) begin n_fail++; $display("FAIL n33_err: got %0d pulses required 1", err_cnt - err0); end
    n_checks++;
    if (O_STATE !== 3'd0) begin n_fail++; $display("FAIL n33_state: got %0d required 0", O_STATE); end
    push(8'd0);
    repeat (4) @(negedge CLK);
    n_checks++;
    if (err_cnt != err0 + 1 || O_STATE !== 3'd0) begin
      n_fail++; $display("FAIL n0_ignored: err pulses %0d state %0d required 1 and 0", err_cnt - err0, O_STATE);
    end
    n_checks++;
    if (rd_ptr != wr_ptr) begin n_fail++; $display("FAIL n0_consumed: %0d bytes left required 0", wr_ptr - rd_ptr); end
    load_and_check(2, "reload2");
  endtask

  task automatic test_run();
    int cnt, d0;
    bit ok;
    d0 = dump_cnt;
    cnt = 0;
    @(negedge CLK); push(8'h01);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (O_CPU_EN) cnt++;
      if (cnt == 10) break;
    end
    @(negedge CLK);
    I_CPU_FINISHED = 1'b1;
    exp_cycles = exp_cycles + 10;
    dump_hs(ok);
    I_CPU_FINISHED = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL run_dump_start: no pulse seen, required one"); end
    n_checks++;
    if (O_CYCLES !== exp_cycles) begin n_fail++; $display("FAIL run_cycles: got %0d required %0d", O_CYCLES, exp_cycles); end
    n_checks++;
    if (dump_cnt != d0 + 1) begin n_fail++; $display("FAIL run_dump_count: got %0d required 1", dump_cnt - d0); end
    n_checks++;
    if (O_STATE !== 3'd3) begin n_fail++; $display("FAIL run_back_to_wait: got %0d required 3", O_STATE); end
  endtask

  task automatic test_step();
    int d0;
    bit ok;
    d0 = dump_cnt;
    for (int s = 0; s < 3; s++) begin
      @(negedge CLK); push(8'h02);
      dump_hs(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL step%0d_dump_start: no pulse, required one", s); end
    end
    exp_cycles = exp_cycles + 3;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (O_CYCLES !== exp_cycles) begin n_fail++; $display("FAIL step3_cycles: got %0d required %0d", O_CYCLES, exp_cycles); end
    n_checks++;
    if (dump_cnt != d0 + 3) begin n_fail++; $display("FAIL step3_dumps: got %0d required 3", dump_cnt - d0); end
    I_CPU_FINISHED = 1'b1;
    @(negedge CLK); push(8'h02);
    dump_hs(ok);
    I_CPU_FINISHED = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (O_CYCLES !== exp_cycles) begin n_fail++; $display("FAIL step_finished_cycles: got %0d required %0d", O_CYCLES, exp_cycles); end
    n_checks++;
    if (dump_cnt != d0 + 4 || O_STATE !== 3'd3) begin
      n_fail++; $display("FAIL step_finished_dump: dumps %0d state %0d required 4 and 3", dump_cnt - d0, O_STATE);
    end
  endtask

  task automatic test_halt();
    int cnt, d0, e0;
    bit ok;
    d0 = dump_cnt;
    cnt = 0;
    @(negedge CLK); push(8'h01);
    repeat (5) begin
      @(negedge CLK);
      if (O_CPU_EN) cnt++;
    end
    @(negedge CLK); push(8'h04);
    #1;
    n_checks++;
    if (O_CPU_EN !== 1'b0 || O_RD_UART !== 1'b1) begin
      n_fail++; $display("FAIL halt_pop_cycle: en %b rd %b required 0 and 1", O_CPU_EN, O_RD_UART);
    end
    exp_cycles = exp_cycles + 5;
    dump_hs(ok);
    repeat (2) @(negedge CLK);
    n_checks++;
    if (cnt != 5 || O_CYCLES !== exp_cycles) begin
      n_fail++; $display("FAIL halt_cycles: seen %0d counter %0d required 5 and %0d", cnt, O_CYCLES, exp_cycles);
    end
    n_checks++;
    if (!ok || dump_cnt != d0 + 1 || O_STATE !== 3'd3) begin
      n_fail++; $display("FAIL halt_dump: dumps %0d state %0d required 1 and 3", dump_cnt - d0, O_STATE);
    end
    // halt byte and finished in the same cycle
    d0 = dump_cnt;
    @(negedge CLK); push(8'h01);
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    I_CPU_FINISHED = 1'b1;
    push(8'h04);
    exp_cycles = exp_cycles + 2;
    dump_hs(ok);
    I_CPU_FINISHED = 1'b0;
    repeat (4) @(negedge CLK);
    n_checks++;
    if (dump_cnt != d0 + 1 || rd_ptr != wr_ptr) begin
      n_fail++; $display("FAIL halt_and_finished: dumps %0d bytes left %0d required 1 and 0", dump_cnt - d0, wr_ptr - rd_ptr);
    end
    n_checks++;
    if (O_CYCLES !== exp_cycles || O_STATE !== 3'd3) begin
      n_fail++; $display("FAIL halt_and_finished_state: cycles %0d state %0d required %0d and 3", O_CYCLES, O_STATE, exp_cycles);
    end
    // unknown command, then dump-only command
    e0 = err_cnt;
    @(negedge CLK); push(8'h7F);
    repeat (3) @(negedge CLK);
    n_checks++;
    if (err_cnt != e0 + 1 || O_STATE !== 3'd3) begin
      n_fail++; $display("FAIL bad_cmd: err pulses %0d state %0d required 1 and 3", err_cnt - e0, O_STATE);
    end
    d0 = dump_cnt;
    push(8'h05);
    dump_hs(ok);
    repeat (2) @(negedge CLK);
    n_checks++;
    if (!ok || dump_cnt != d0 + 1 || O_CYCLES !== exp_cycles) begin
      n_fail++; $display("FAIL dump_only: dumps %0d cycles %0d required 1 and %0d", dump_cnt - d0, O_CYCLES, exp_cycles);
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int e0;
    @(negedge CLK); push(8'h03);
    wait_state(3'd0, 20, ok);
    push(8'h02); push(8'h11); push(8'h22); push(8'h33);
    repeat (6) @(negedge CLK);
    n_checks++;
    if (O_STATE !== 3'd1 || O_CPU_CLR !== 1'b1) begin
      n_fail++; $display("FAIL mid_load_state: state %0d clr %b required 1 and 1", O_STATE, O_CPU_CLR);
    end
    @(negedge CLK);
    RESET = 1'b0;
    push(8'h44);
    #1;
    n_checks++;
    if ({O_RD_UART, O_PM_WE, O_CPU_CLR, O_CPU_EN, O_DUMP_START, O_ERR} !== 6'b0 || O_STATE !== 3'd0) begin
      n_fail++; $display("FAIL async_reset_strobes: %b state %0d required 000000 and 0",
                         {O_RD_UART, O_PM_WE, O_CPU_CLR, O_CPU_EN, O_DUMP_START, O_ERR}, O_STATE);
    end
    n_checks++;
    if (O_PM_ADDR !== '0 || O_PM_DATA !== '0 || O_CYCLES !== '0) begin
      n_fail++; $display("FAIL async_reset_values: addr %h data %h cycles %0d required 0", O_PM_ADDR, O_PM_DATA, O_CYCLES);
    end
    repeat (2) @(negedge CLK);
    n_checks++;
    if (wr_ptr - rd_ptr != 1) begin n_fail++; $display("FAIL reset_no_pop: %0d bytes left required 1", wr_ptr - rd_ptr); end
    e0 = err_cnt;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (err_cnt != e0 + 1 || O_STATE !== 3'd0 || rd_ptr != wr_ptr) begin
      n_fail++; $display("FAIL after_reset_n: err %0d state %0d left %0d required 1, 0, 0", err_cnt - e0, O_STATE, wr_ptr - rd_ptr);
    end
    load_and_check(1, "after_reset");
  endtask

  task automatic test_invariants();
    n_checks++;
    if (bad_pop != 0) begin n_fail++; $display("FAIL empty_pop: got %0d required 0", bad_pop); end
    n_checks++;
    if (err_we_bad != 0) begin n_fail++; $display("FAIL err_with_we: got %0d required 0", err_we_bad); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) fifo_mem[i] = 8'h00;
    test_reset();
    test_load2();
    test_boundary();
    test_run();
    test_step();
    test_halt();
    test_reset_mid_load();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_load_ctrl.md
Name: program_load_ctrl

Overview:
- Parametrised successor to the MIPS top-level loader/step controller.
- Pops bytes from the UART RX FIFO, assembles DATA_W-bit instructions and writes them into MIPS program memory, zero-filling unused addresses.
- Then drives the CPU with a clock-enable in run, step or halt mode and hands off to the debug unit for register dumps.
- Replaces the gated clock (CLK && R_D) with a synchronous O_CPU_EN.

Parameters:
- DATA_W, 32, instruction width in bits; must be a multiple of 8.
- ADDR_W, 5, program memory address width; DEPTH = 2**ADDR_W.
- CNT_W, 32, width of the executed-cycle counter.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous reset, active-low.
- I_RX_EMPTY  input  1  RX FIFO empty.
- I_RX_DATA  input  8  RX FIFO head byte (first-word-fall-through).
- O_RD_UART  output  1  pop strobe for the RX FIFO.
- O_PM_WE  output  1  program memory write enable.
- O_PM_ADDR  output  ADDR_W  program memory write address.
- O_PM_DATA  output  DATA_W  program memory write data.
- O_CPU_CLR  output  1  holds the CPU pipeline in reset during load.
- O_CPU_EN  output  1  CPU clock enable.
- I_CPU_FINISHED  input  1  CPU reached its halt instruction.
- O_DUMP_START  output  1  one-cycle pulse that starts a debug-unit dump.
- I_DUMP_DONE  input  1  debug unit finished transmitting.
- O_CYCLES  output  CNT_W  count of enabled CPU cycles.
- O_ERR  output  1  one-cycle pulse on a protocol error.
- O_STATE  output  3  current state encoding, for the debug dump.

Behaviour:
- Reset (RESET low, async): state IDLE, counters cleared.
  - All outputs are 0; O_PM_ADDR is 0 and O_PM_DATA is 0.
  - Reset mid-load or mid-run abandons the operation; PM contents already written are left as they are.
- FIFO handshake: a byte is consumed only when O_RD_UART=1 and I_RX_EMPTY=0 in the same cycle. I_RX_DATA is sampled in that cycle. The block never pops an empty FIFO and pops at most one byte per cycle.
- IDLE: pop one byte as N.
  - N==0: ignored, stay IDLE.
  - N>DEPTH: O_ERR pulse, stay IDLE.
  - Otherwise: word index cleared, cycle counter cleared, go to LOAD.
- LOAD: O_CPU_CLR=1.
  - Bytes are shifted in MSB-first; DATA_W/8 bytes make one word.
  - On the cycle the last byte of a word is popped, the following cycle has O_PM_WE=1, O_PM_ADDR=index, O_PM_DATA=word, and the index increments.
  - After word N-1 is written, go to FILL. If N==DEPTH, go directly to WAIT_CMD with no wrap.
  - Stalls while the FIFO is empty have no timeout.
- FILL: O_CPU_CLR=1. One write per cycle with O_PM_DATA=0 (NOP) at addresses N..DEPTH-1, then WAIT_CMD.
- WAIT_CMD: O_CPU_CLR=0. Pop one command byte:
  - 0x01: go to RUN.
  - 0x02: go to STEP.
  - 0x03: reload, go to IDLE.
  - 0x05: go to DUMP with no execution.
  - Any other byte: O_ERR pulse, stay in WAIT_CMD.
- RUN: O_CPU_EN=1 every cycle while I_CPU_FINISHED=0.
  - I_CPU_FINISHED=1: O_CPU_EN drops in that same cycle (combinational gate), go to DUMP.
  - RX byte 0x04 (halt): popped; O_CPU_EN=0 from the pop cycle onward, go to DUMP.
  - Any other RX byte is not popped during RUN.
- STEP: exactly one cycle of O_CPU_EN=1, then DUMP. If I_CPU_FINISHED=1 on entry, there is no enable cycle and the block goes straight to DUMP.
- DUMP: O_DUMP_START pulses on the first cycle of DUMP only. Wait for I_DUMP_DONE=1, then go to WAIT_CMD. I_DUMP_DONE asserted in the same cycle as the pulse is accepted.
- O_CYCLES: +1 on every cycle with O_CPU_EN=1. Saturates at all-ones and clears on entry to LOAD.
- Simultaneous events: in RUN, finished and halt in the same cycle → halt byte is popped, one DUMP only.
- O_ERR is never asserted together with O_PM_WE.
- O_STATE encoding: IDLE=0, LOAD=1, FILL=2, WAIT_CMD=3, RUN=4, STEP=5, DUMP=6.

Test Plan:
- Load 2 words: push 02,11,22,33,44,AA,BB,CC,DD → PM[0]=0x11223344, PM[1]=0xAABBCCDD, PM[2..31]=0. O_CPU_CLR high throughout, 32 total PM writes, then O_STATE=3.
- Boundary count: N=32 gives no FILL and last write at addr 31. N=33 → one O_ERR pulse, stays IDLE. N=0 → stays IDLE with no error.
- Run: command 01, I_CPU_FINISHED raised after 10 enabled cycles → O_CYCLES=10, one O_DUMP_START pulse, back to WAIT_CMD after I_DUMP_DONE.
- Step ×3: three 02 commands with DUMP handshakes → O_CYCLES=3 and three dump pulses. Step with I_CPU_FINISHED=1 → O_CYCLES unchanged.
- Halt: 01, then 04 pushed during RUN → O_CPU_EN low from the pop cycle onward. Unknown byte 7F in WAIT_CMD → O_ERR pulse.
- Reset low asserted mid-LOAD (after 3 bytes) → all outputs 0 asynchronously. After release the block is in IDLE and the next byte is treated as N.
